rca32_checked: RTL and testbench

- Registered 32-bit ripple-carry adder: a, b and a 1-bit carry-in produce a 32-bit sum, carry-out and signed-overflow flag.
- Built as a structural chain of full-adder cells, so carry ripples bit 0 → bit 31.
- A behavioural reference sum is computed in parallel; any disagreement raises a mismatch flag.
- Sits in datapaths as a drop-in registered adder and a self-checking carrier for the ripple structure.

---
 rtl/rca32_checked.sv | 92 +++++++++
 tb/tb_rca32_checked.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/rca32_checked.sv
//------------------------------------------------------------------------------
// rca32_checked : registered ripple-carry adder with behavioural cross-check
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rca32_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic w_p;

  assign w_p = a ^ b;
  assign s   = w_p ^ ci;
  assign co  = (a & b) | (ci & w_p);
endmodule

module rca32_checked #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             mismatch
);
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH:0]   w_ref;
  logic             w_disagree;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_mismatch;

  assign w_c[0] = cin;

  // Carry ripples strictly bit 0 -> bit WIDTH-1; no lookahead.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      rca32_fa u_fa (
        .a  (a[i]),
        .b  (b[i]),
        .ci (w_c[i]),
        .s  (w_s[i]),
        .co (w_c[i+1])
      );
    end
  endgenerate

  assign w_ref      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign w_disagree = ({w_c[WIDTH], w_s} != w_ref);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_mismatch  <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum  <= w_s;
        r_cout <= w_c[WIDTH];
        r_ovf  <= w_c[WIDTH-1] ^ w_c[WIDTH];
        if (w_disagree) begin
          r_mismatch <= 1'b1;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign mismatch  = r_mismatch;
endmodule

`default_nettype wire

// File: tb/tb_rca32_checked.sv
// Directed-vector and random bench for rca32_checked.
`default_nettype none

module tb_rca32_checked;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        out_valid;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        mismatch;

  int total = 0;
  int bad   = 0;

  rca32_checked #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .mismatch  (mismatch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, sample 1 time unit after the next rising edge.
  task automatic step(input logic v, input logic [31:0] aa, input logic [31:0] bb, input logic cc);
    @(negedge clk);
    in_valid = v;
    a        = aa;
    b        = bb;
    cin      = cc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [32:0] m_full;
    logic        m_ovf;
    logic [31:0] ra, rb;
    logic        rc;
    logic [31:0] held_sum;
    logic        held_cout;

    vecs[0]  = '{32'd80231,     32'd4234950,  1'b0, 32'd4315181,   1'b0, 1'b0};
    vecs[1]  = '{32'd100000000, 32'd13,       1'b0, 32'd100000013, 1'b0, 1'b0};
    vecs[2]  = '{32'd0,         32'd0,        1'b0, 32'd0,         1'b0, 1'b0};
    vecs[3]  = '{32'd130,       32'd231,      1'b0, 32'd361,       1'b0, 1'b0};
    vecs[4]  = '{32'd80231,     32'd4234950,  1'b1, 32'd4315182,   1'b0, 1'b0};
    vecs[5]  = '{32'd100000000, 32'd13,       1'b1, 32'd100000014, 1'b0, 1'b0};
    vecs[6]  = '{32'd0,         32'd0,        1'b1, 32'd1,         1'b0, 1'b0};
    vecs[7]  = '{32'd130,       32'd231,      1'b1, 32'd362,       1'b0, 1'b0};
    vecs[8]  = '{32'hFFFFFFFF,  32'h0,        1'b1, 32'h0,         1'b1, 1'b0};
    vecs[9]  = '{32'hFFFFFFFF,  32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF,  1'b1, 1'b0};
    vecs[10] = '{32'h7FFFFFFF,  32'h1,        1'b0, 32'h80000000,  1'b0, 1'b1};
    vecs[11] = '{32'h80000000,  32'h80000000, 1'b0, 32'h0,         1'b1, 1'b1};
    vecs[12] = '{32'h80000000,  32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF,  1'b1, 1'b1};
    vecs[13] = '{32'h40000000,  32'h40000000, 1'b0, 32'h80000000,  1'b0, 1'b1};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_sum",       {32'd0, sum},       64'd0);
    chk("reset_cout_ovf",  {62'd0, cout, ovf}, 64'd0);
    chk("reset_mismatch",  {63'd0, mismatch},  64'd0);

    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
      chk($sformatf("vec%0d_sum", i),       {32'd0, sum},       {32'd0, vecs[i].exp_sum});
      chk($sformatf("vec%0d_cout", i),      {63'd0, cout},      {63'd0, vecs[i].exp_cout});
      chk($sformatf("vec%0d_ovf", i),       {63'd0, ovf},       {63'd0, vecs[i].exp_ovf});
      chk($sformatf("vec%0d_out_valid", i), {63'd0, out_valid}, 64'd1);
    end

    // Hold: a valid op, then idle cycles with different operands.
    step(1'b1, 32'd1000, 32'd234, 1'b0);
    chk("hold_pre_sum", {32'd0, sum}, 64'd1234);
    held_sum  = sum;
    held_cout = cout;
    step(1'b0, 32'hFFFFFFFF, 32'h5, 1'b1);
    chk("hold_out_valid", {63'd0, out_valid}, 64'd0);
    chk("hold_sum",       {32'd0, sum},       {32'd0, 32'd1234});
    chk("hold_cout",      {63'd0, cout},      {63'd0, held_cout});
    step(1'b0, 32'h12345678, 32'h9, 1'b0);
    chk("hold2_sum", {32'd0, sum}, {32'd0, held_sum});
    step(1'b1, 32'd5, 32'd6, 1'b1);
    chk("resume_sum",       {32'd0, sum},       64'd12);
    chk("resume_out_valid", {63'd0, out_valid}, 64'd1);

    // Reset while a valid operation is presented.
    step(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 32'h80000000;
    b        = 32'h80000000;
    @(posedge clk);
    #1;
    chk("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mid_sum",       {32'd0, sum},       64'd0);
    chk("rst_mid_cout_ovf",  {62'd0, cout, ovf}, 64'd0);
    chk("rst_mid_mismatch",  {63'd0, mismatch},  64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 10000; n++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      case (n % 16)
        0: ra = 32'hFFFFFFFF;
        1: rb = 32'h80000000;
        2: ra = 32'h7FFFFFFF;
        default: ;
      endcase
      m_full = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      m_ovf  = (ra[31] == rb[31]) && (m_full[31] != ra[31]);
      step(1'b1, ra, rb, rc);
      chk($sformatf("rand%0d", n),
          {29'd0, out_valid, ovf, cout, sum},
          {29'd0, 1'b1, m_ovf, m_full[32], m_full[31:0]});
    end
    chk("rand_mismatch", {63'd0, mismatch}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
